// File: rtl/issue_pair_ctrl_if.sv
// Signal bundle between the dual-issue ID stage and its hazard/pairing controller.
// The controller takes the slave side; the pipeline (or a bench) takes the master side.
interface issue_pair_ctrl_if;
    logic        v0;
    logic        v1;
    logic        oldest_id;
    logic [4:0]  rs0;
    logic [4:0]  rt0;
    logic [4:0]  rs1;
    logic [4:0]  rt1;
    logic [4:0]  wr0;
    logic [4:0]  wr1;
    logic        rw0;
    logic        rw1;
    logic        mem0;
    logic        mem1;
    logic        ex_mr0;
    logic        ex_mr1;
    logic [4:0]  ex_wr0;
    logic [4:0]  ex_wr1;
    logic        mispredict;
    logic        stall_id;
    logic        flush_ex0;
    logic        flush_ex1;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    modport master (
        output v0, v1, oldest_id, rs0, rt0, rs1, rt1, wr0, wr1, rw0, rw1,
               mem0, mem1, ex_mr0, ex_mr1, ex_wr0, ex_wr1, mispredict,
        input  stall_id, flush_ex0, flush_ex1, state, stall_cnt
    );

    modport slave (
        input  v0, v1, oldest_id, rs0, rt0, rs1, rt1, wr0, wr1, rw0, rw1,
               mem0, mem1, ex_mr0, ex_mr1, ex_wr0, ex_wr1, mispredict,
        output stall_id, flush_ex0, flush_ex1, state, stall_cnt
    );
endinterface

// File: rtl/issue_pair_ctrl.sv
// Dual-issue ID-stage controller: load-use stalls, splitting of dependent or
// dual-memory pairs into older-then-younger issue, and mispredict flush.
module issue_pair_ctrl (
    input  logic               clk,
    input  logic               Reset,
    issue_pair_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SPLIT  = 2'd1,
        SPLIT2 = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        split_o;
    logic [15:0] stall_cnt_q;
    logic        lu0;
    logic        lu1;
    logic        lu_any;
    logic        lu_young;
    logic        pair_raw;
    logic        pc;
    logic        stall;
    logic        f0;
    logic        f1;

    // Register 0 is hardwired zero, so it can never create a dependency.
    function automatic logic src_hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    always_comb begin
        lu0 = bus.v0 && ((bus.ex_mr0 && (src_hit(bus.rs0, bus.ex_wr0) || src_hit(bus.rt0, bus.ex_wr0))) ||
                         (bus.ex_mr1 && (src_hit(bus.rs0, bus.ex_wr1) || src_hit(bus.rt0, bus.ex_wr1))));
        lu1 = bus.v1 && ((bus.ex_mr0 && (src_hit(bus.rs1, bus.ex_wr0) || src_hit(bus.rt1, bus.ex_wr0))) ||
                         (bus.ex_mr1 && (src_hit(bus.rs1, bus.ex_wr1) || src_hit(bus.rt1, bus.ex_wr1))));
        lu_any   = lu0 || lu1;
        lu_young = split_o ? lu0 : lu1;
        if (bus.oldest_id)
            pair_raw = bus.rw1 && (src_hit(bus.rs0, bus.wr1) || src_hit(bus.rt0, bus.wr1));
        else
            pair_raw = bus.rw0 && (src_hit(bus.rs1, bus.wr0) || src_hit(bus.rt1, bus.wr0));
        pc = bus.v0 && bus.v1 && (pair_raw || (bus.mem0 && bus.mem1));
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.mispredict) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                RUN:    state_d = (!lu_any && pc) ? SPLIT : RUN;
                SPLIT:  state_d = SPLIT2;
                SPLIT2: state_d = lu_young ? SPLIT2 : RUN;
                FLUSH:  state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall = 1'b0;
        f0    = 1'b1;
        f1    = 1'b1;
        if (!Reset && !bus.mispredict) begin
            case (state_q)
                RUN: begin
                    if (lu_any) begin
                        stall = 1'b1;
                    end else if (pc) begin
                        stall = 1'b1;
                        f0    = bus.oldest_id;
                        f1    = !bus.oldest_id;
                    end else begin
                        f0 = !bus.v0;
                        f1 = !bus.v1;
                    end
                end
                SPLIT:  stall = 1'b1;
                SPLIT2: begin
                    if (lu_young) begin
                        stall = 1'b1;
                    end else begin
                        f0 = !split_o;
                        f1 = split_o;
                    end
                end
                FLUSH:  stall = 1'b0;
            endcase
        end
    end

    // split_o remembers which way went first so SPLIT2 releases the other one.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            split_o <= 1'b0;
        else if (state_q == RUN && state_d == SPLIT)
            split_o <= bus.oldest_id;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            stall_cnt_q <= 16'd0;
        else if (stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign bus.stall_id  = stall;
    assign bus.flush_ex0 = f0;
    assign bus.flush_ex1 = f1;
    assign bus.state     = state_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_pair_ctrl.sv
// Directed bench for issue_pair_ctrl: each driven cycle queues its expected
// outputs, which are popped and compared against the DUT before the next edge.
module tb_issue_pair_ctrl;

    logic clk;
    logic Reset;
    int   total;
    int   bad;

    typedef struct {
        string       tag;
        logic        stall;
        logic        f0;
        logic        f1;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    issue_pair_ctrl_if bus ();

    issue_pair_ctrl dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input string tag, input logic stall, input logic f0, input logic f1,
                           input logic [1:0] st, input logic [15:0] cnt);
        exp_t e;
        e.tag = tag; e.stall = stall; e.f0 = f0; e.f1 = f1; e.st = st; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic sampleOutputs();
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            checkOutput({e.tag, ".stall"}, {31'd0, bus.stall_id},  {31'd0, e.stall});
            checkOutput({e.tag, ".f0"},    {31'd0, bus.flush_ex0}, {31'd0, e.f0});
            checkOutput({e.tag, ".f1"},    {31'd0, bus.flush_ex1}, {31'd0, e.f1});
            checkOutput({e.tag, ".state"}, {30'd0, bus.state},     {30'd0, e.st});
            checkOutput({e.tag, ".cnt"},   {16'd0, bus.stall_cnt}, {16'd0, e.cnt});
        end
    endtask

    // Inputs are already driven just after a falling edge; sample 2ns later, then move to the next falling edge.
    task automatic applyStimulus(input string tag, input logic stall, input logic f0, input logic f1,
                                 input logic [1:0] st, input logic [15:0] cnt);
        pushExp(tag, stall, f0, f1, st, cnt);
        #2;
        sampleOutputs();
        @(negedge clk);
    endtask

    task automatic setIndependent();
        bus.v0 = 1'b1; bus.v1 = 1'b1; bus.oldest_id = 1'b0;
        bus.rs0 = 5'd1; bus.rt0 = 5'd2; bus.rs1 = 5'd3; bus.rt1 = 5'd4;
        bus.wr0 = 5'd5; bus.wr1 = 5'd6; bus.rw0 = 1'b1; bus.rw1 = 1'b1;
        bus.mem0 = 1'b0; bus.mem1 = 1'b0;
        bus.ex_mr0 = 1'b0; bus.ex_mr1 = 1'b0; bus.ex_wr0 = 5'd0; bus.ex_wr1 = 5'd0;
        bus.mispredict = 1'b0;
    endtask

    // Way1 reads r5, which older way0 writes.
    task automatic setPairRaw();
        setIndependent();
        bus.rs1 = 5'd5;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        setIndependent();
        #2;
        pushExp("reset", 1'b0, 1'b1, 1'b1, 2'd0, 16'd0);
        sampleOutputs();
        @(negedge clk);
        Reset = 1'b0;

        setIndependent();
        applyStimulus("indep_a", 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
        applyStimulus("indep_b", 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
        bus.v1 = 1'b0;
        applyStimulus("v1_bubble", 1'b0, 1'b0, 1'b1, 2'd0, 16'd0);

        setIndependent();
        bus.wr0 = 5'd0; bus.rs1 = 5'd0; bus.rs0 = 5'd0; bus.ex_mr1 = 1'b1; bus.ex_wr1 = 5'd0;
        applyStimulus("reg0_nohit", 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);

        setIndependent();
        bus.ex_mr1 = 1'b1; bus.ex_wr1 = 5'd5; bus.rs0 = 5'd5;
        applyStimulus("lu_way0", 1'b1, 1'b1, 1'b1, 2'd0, 16'd0);
        setIndependent();
        bus.ex_mr0 = 1'b1; bus.ex_wr0 = 5'd4;
        applyStimulus("lu_way1_rt", 1'b1, 1'b1, 1'b1, 2'd0, 16'd1);
        bus.v1 = 1'b0;
        applyStimulus("lu_invalid", 1'b0, 1'b0, 1'b1, 2'd0, 16'd2);
        setIndependent();
        applyStimulus("lu_release", 1'b0, 1'b0, 1'b0, 2'd0, 16'd2);

        setPairRaw();
        applyStimulus("raw_c0", 1'b1, 1'b0, 1'b1, 2'd0, 16'd2);
        applyStimulus("raw_c1", 1'b1, 1'b1, 1'b1, 2'd1, 16'd3);
        applyStimulus("raw_c2", 1'b0, 1'b1, 1'b0, 2'd2, 16'd4);
        setIndependent();
        applyStimulus("raw_after", 1'b0, 1'b0, 1'b0, 2'd0, 16'd4);

        setIndependent();
        bus.oldest_id = 1'b1; bus.mem0 = 1'b1; bus.mem1 = 1'b1;
        applyStimulus("mem_c0", 1'b1, 1'b1, 1'b0, 2'd0, 16'd4);
        applyStimulus("mem_c1", 1'b1, 1'b1, 1'b1, 2'd1, 16'd5);
        applyStimulus("mem_c2", 1'b0, 1'b0, 1'b1, 2'd2, 16'd6);
        setIndependent();
        applyStimulus("mem_after", 1'b0, 1'b0, 1'b0, 2'd0, 16'd6);

        setPairRaw();
        applyStimulus("s2old_c0", 1'b1, 1'b0, 1'b1, 2'd0, 16'd6);
        applyStimulus("s2old_c1", 1'b1, 1'b1, 1'b1, 2'd1, 16'd7);
        bus.ex_mr0 = 1'b1; bus.ex_wr0 = 5'd9; bus.rt0 = 5'd9;
        applyStimulus("s2old_c2", 1'b0, 1'b1, 1'b0, 2'd2, 16'd8);
        setIndependent();
        applyStimulus("s2old_after", 1'b0, 1'b0, 1'b0, 2'd0, 16'd8);

        setPairRaw();
        applyStimulus("s2lu_c0", 1'b1, 1'b0, 1'b1, 2'd0, 16'd8);
        applyStimulus("s2lu_c1", 1'b1, 1'b1, 1'b1, 2'd1, 16'd9);
        bus.ex_mr0 = 1'b1; bus.ex_wr0 = 5'd9; bus.rt1 = 5'd9;
        applyStimulus("s2lu_c2", 1'b1, 1'b1, 1'b1, 2'd2, 16'd10);
        bus.ex_mr0 = 1'b0;
        applyStimulus("s2lu_c3", 1'b0, 1'b1, 1'b0, 2'd2, 16'd11);
        setIndependent();
        applyStimulus("s2lu_after", 1'b0, 1'b0, 1'b0, 2'd0, 16'd11);

        setPairRaw();
        applyStimulus("mis_c0", 1'b1, 1'b0, 1'b1, 2'd0, 16'd11);
        applyStimulus("mis_c1", 1'b1, 1'b1, 1'b1, 2'd1, 16'd12);
        bus.mispredict = 1'b1;
        applyStimulus("mis_s2", 1'b0, 1'b1, 1'b1, 2'd2, 16'd13);
        setIndependent();
        applyStimulus("mis_flush", 1'b0, 1'b1, 1'b1, 2'd3, 16'd13);
        applyStimulus("mis_run", 1'b0, 1'b0, 1'b0, 2'd0, 16'd13);

        setIndependent();
        bus.ex_mr1 = 1'b1; bus.ex_wr1 = 5'd5; bus.rs0 = 5'd5; bus.mispredict = 1'b1;
        applyStimulus("mis_over_lu", 1'b0, 1'b1, 1'b1, 2'd0, 16'd13);
        setIndependent();
        applyStimulus("mis_run_flush", 1'b0, 1'b1, 1'b1, 2'd3, 16'd13);
        applyStimulus("mis_run_back", 1'b0, 1'b0, 1'b0, 2'd0, 16'd13);

        setIndependent();
        bus.ex_mr1 = 1'b1; bus.ex_wr1 = 5'd5; bus.rs0 = 5'd5;
        for (int i = 0; i < 65522; i++) @(negedge clk);
        applyStimulus("sat_a", 1'b1, 1'b1, 1'b1, 2'd0, 16'hFFFF);
        applyStimulus("sat_b", 1'b1, 1'b1, 1'b1, 2'd0, 16'hFFFF);

        setPairRaw();
        applyStimulus("rst_c0", 1'b1, 1'b0, 1'b1, 2'd0, 16'hFFFF);
        pushExp("rst_split", 1'b1, 1'b1, 1'b1, 2'd1, 16'hFFFF);
        #1;
        sampleOutputs();
        #1;
        Reset = 1'b1;
        #1;
        pushExp("rst_async", 1'b0, 1'b1, 1'b1, 2'd0, 16'd0);
        sampleOutputs();
        @(negedge clk);
        Reset = 1'b0;
        applyStimulus("rst_post", 1'b1, 1'b0, 1'b1, 2'd0, 16'd0);

        if (sb.size() != 0)
            checkOutput("scoreboard_left", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
